// File: rtl/mux_rr_nx1.sv
// mux_rr_nx1: N:1 registered channel multiplexer with per-lane pop strobes.
// Two run-time modes:
//   mode=0  TDM: one fixed slot per advance, an empty slot emits idle.
//   mode=1  round-robin: skips empty lanes, starting the search at ptr.
// Handshake: an advance happens on every rising edge with out_ready=1.
// pop[i] is a combinational strobe meaning "lane i is consumed on this edge".
// Optional feature macro: MUX_RR_CH_ID_EN adds the ch_id output (source lane of data_out).
module mux_rr_nx1 #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4,
  localparam int SEL_W = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [WIDTH*NUM_CH-1:0] data_in,
  input  logic [NUM_CH-1:0]       valid_in,
  output logic [NUM_CH-1:0]       pop,
  input  logic                    mode,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        data_out,
  output logic                    valid_out
`ifdef MUX_RR_CH_ID_EN
  ,
  output logic [SEL_W-1:0]        ch_id
`endif
);

  logic [SEL_W-1:0]    ptr;
  logic [SEL_W-1:0]    ptr_nxt;
  logic [2*NUM_CH-1:0] valid_dbl;
  logic [NUM_CH-1:0]   valid_rot;
  logic                sel_found;
  int                  sel_off;
  int                  sel_idx;
  logic [WIDTH-1:0]    sel_data;
  logic                fire;

  // Choose the lane to serve: the slot at ptr (TDM) or the first valid lane at or after ptr (RR).
  always_comb begin
    valid_dbl = {valid_in, valid_in};
    valid_rot = valid_dbl[NUM_CH-1:0];
    sel_found = 1'b0;
    sel_off   = 0;
    sel_idx   = int'(ptr);
    if (!mode) begin
      sel_found = valid_in[ptr];
    end else begin
      valid_dbl = valid_dbl >> ptr;
      valid_rot = valid_dbl[NUM_CH-1:0];
      for (int i = 0; i < NUM_CH; i++) begin
        if (!sel_found && valid_rot[i]) begin
          sel_found = 1'b1;
          sel_off   = i;
        end
      end
      sel_idx = int'(ptr) + sel_off;
      if (sel_idx >= NUM_CH) sel_idx = sel_idx - NUM_CH;
    end
  end

  // Mux the selected lane's data and raise its pop strobe when the stage advances.
  always_comb begin
    sel_data = '0;
    pop      = '0;
    fire     = reset && out_ready && sel_found;
    for (int c = 0; c < NUM_CH; c++) begin
      if (c == sel_idx) begin
        sel_data = data_in[c*WIDTH +: WIDTH];
        pop[c]   = fire;
      end
    end
  end

  // Next slot pointer; wrap is an explicit compare so non-power-of-two NUM_CH works.
  always_comb begin
    ptr_nxt = ptr;
    if (!mode) begin
      ptr_nxt = (ptr == SEL_W'(NUM_CH - 1)) ? '0 : ptr + SEL_W'(1);
    end else if (sel_found) begin
      ptr_nxt = (sel_idx == NUM_CH - 1) ? '0 : SEL_W'(sel_idx + 1);
    end
  end

  // Output stage and pointer; everything holds while out_ready is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr       <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
    end else if (out_ready) begin
      ptr       <= ptr_nxt;
      valid_out <= sel_found;
      data_out  <= sel_found ? sel_data : '0;
    end
  end

`ifdef MUX_RR_CH_ID_EN
  // Source lane tag: TDM always records the slot, RR only updates when a lane was served.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ch_id <= '0;
    end else if (out_ready && (!mode || sel_found)) begin
      ch_id <= SEL_W'(sel_idx);
    end
  end
`endif

endmodule

// File: tb/tb_mux_rr_nx1.sv
// tb_mux_rr_nx1: drives a 4-lane and a 3-lane mux_rr_nx1 with shared stimulus;
// a lane-level model predicts pops and registered outputs into queues,
// and a monitor process pops and compares them.
// Optional feature macro: MUX_RR_CH_ID_EN (ch_id outputs checked when defined).
module tb_mux_rr_nx1;

  logic        clk;
  logic        reset;
  logic        mode;
  logic        out_ready;
  logic [31:0] din;
  logic [3:0]  vin;
  logic [3:0]  pop4;
  logic [2:0]  pop3;
  logic [7:0]  dout4, dout3;
  logic        vout4, vout3;
`ifdef MUX_RR_CH_ID_EN
  logic [1:0]  chid4, chid3;
`endif

  int total;
  int bad;

  // model state per instance: 0 = 4-lane, 1 = 3-lane
  int         m_ptr[2];
  int         m_chid[2];
  logic [7:0] m_data[2];
  logic       m_valid[2];

  // expected registered output {ch_id[1:0], valid, data[7:0]} and expected pop
  logic [10:0] exp_q4[$];
  logic [10:0] exp_q3[$];
  logic [3:0]  pop_q4[$];
  logic [3:0]  pop_q3[$];

  mux_rr_nx1 #(.WIDTH(8), .NUM_CH(4)) dut4 (
    .clk(clk), .reset(reset), .data_in(din), .valid_in(vin), .pop(pop4),
    .mode(mode), .out_ready(out_ready), .data_out(dout4), .valid_out(vout4)
`ifdef MUX_RR_CH_ID_EN
    , .ch_id(chid4)
`endif
  );

  mux_rr_nx1 #(.WIDTH(8), .NUM_CH(3)) dut3 (
    .clk(clk), .reset(reset), .data_in(din[23:0]), .valid_in(vin[2:0]), .pop(pop3),
    .mode(mode), .out_ready(out_ready), .data_out(dout3), .valid_out(vout3)
`ifdef MUX_RR_CH_ID_EN
    , .ch_id(chid3)
`endif
  );

  // clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one edge of an n-lane mux, stated in terms of lanes and slots.
  task automatic model_step(input int inst, input int n, output logic [3:0] ep);
    int k;
    ep = '0;
    if (!reset) begin
      m_ptr[inst]   = 0;
      m_chid[inst]  = 0;
      m_data[inst]  = '0;
      m_valid[inst] = 1'b0;
    end else if (out_ready) begin
      if (!mode) begin
        k = m_ptr[inst];
        m_chid[inst] = k;
        m_valid[inst] = vin[k];
        m_data[inst] = vin[k] ? din[k*8 +: 8] : 8'h00;
        if (vin[k]) ep[k] = 1'b1;
        m_ptr[inst] = (k + 1) % n;
      end else begin
        k = -1;
        for (int off = 0; off < n; off++)
          if (k < 0 && vin[(m_ptr[inst] + off) % n]) k = (m_ptr[inst] + off) % n;
        if (k >= 0) begin
          m_chid[inst] = k;
          m_valid[inst] = 1'b1;
          m_data[inst] = din[k*8 +: 8];
          ep[k] = 1'b1;
          m_ptr[inst] = (k + 1) % n;
        end else begin
          m_valid[inst] = 1'b0;
          m_data[inst] = 8'h00;
        end
      end
    end
  endtask

  // Driver: one cycle of stimulus applied after a falling edge, expectations queued.
  task automatic drive(input logic rst_v, input logic mode_v, input logic rdy_v,
                       input logic [3:0] vin_v, input logic [31:0] din_v);
    logic [3:0] ep;
    @(negedge clk);
    reset = rst_v;
    mode = mode_v;
    out_ready = rdy_v;
    vin = vin_v;
    din = din_v;
    model_step(0, 4, ep);
    pop_q4.push_back(ep);
    exp_q4.push_back({2'(m_chid[0]), m_valid[0], m_data[0]});
    model_step(1, 3, ep);
    pop_q3.push_back(ep);
    exp_q3.push_back({2'(m_chid[1]), m_valid[1], m_data[1]});
  endtask

  // Monitor: pops checked mid-cycle, registered outputs checked just after each rising edge.
  initial begin : monitor
    logic [10:0] e;
    logic [3:0]  p;
    forever begin
      @(negedge clk);
      #2;
      if (!reset) begin
        check("rst_data4", {24'h0, dout4}, 32'h0);
        check("rst_valid4", {31'h0, vout4}, 32'h0);
      end
      if (pop_q4.size() == 0 || pop_q3.size() == 0) begin
        check("pop_q_empty", 32'(pop_q4.size() + pop_q3.size()), 32'd2);
      end else begin
        p = pop_q4.pop_front();
        check("pop4", {28'h0, pop4}, {28'h0, p});
        p = pop_q3.pop_front();
        check("pop3", {29'h0, pop3}, {29'h0, p[2:0]});
      end
      @(posedge clk);
      #1;
      if (exp_q4.size() == 0 || exp_q3.size() == 0) begin
        check("exp_q_empty", 32'(exp_q4.size() + exp_q3.size()), 32'd2);
      end else begin
        e = exp_q4.pop_front();
        check("data4", {24'h0, dout4}, {24'h0, e[7:0]});
        check("valid4", {31'h0, vout4}, {31'h0, e[8]});
`ifdef MUX_RR_CH_ID_EN
        check("chid4", {30'h0, chid4}, {30'h0, e[10:9]});
`endif
        e = exp_q3.pop_front();
        check("data3", {24'h0, dout3}, {24'h0, e[7:0]});
        check("valid3", {31'h0, vout3}, {31'h0, e[8]});
`ifdef MUX_RR_CH_ID_EN
        check("chid3", {30'h0, chid3}, {30'h0, e[10:9]});
`endif
      end
    end
  end

  // Stimulus sequence and final report.
  initial begin : stim
    total = 0;
    bad = 0;
    reset = 1'b0;
    mode = 1'b0;
    out_ready = 1'b0;
    vin = '0;
    din = '0;
    repeat (3) drive(1'b0, 1'b0, 1'b1, 4'h0, 32'h0);
    // TDM, all lanes valid
    repeat (10) drive(1'b1, 1'b0, 1'b1, 4'hF, 32'h43322110);
    // TDM, only lane 2 valid
    repeat (8) drive(1'b1, 1'b0, 1'b1, 4'h4, 32'h00A50000);
    // RR, lanes 1 and 3 valid
    repeat (8) drive(1'b1, 1'b1, 1'b1, 4'hA, 32'h33001100);
    // mid-stream reset, then TDM from lane 0
    drive(1'b0, 1'b0, 1'b1, 4'hF, 32'h43322110);
    repeat (5) drive(1'b1, 1'b0, 1'b1, 4'hF, 32'h43322110);
    // RR all valid with a 3-cycle stall, inputs wiggling during the stall
    drive(1'b0, 1'b1, 1'b1, 4'hF, 32'h44332211);
    repeat (2) drive(1'b1, 1'b1, 1'b1, 4'hF, 32'h44332211);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 4'(i + 1), $urandom);
    repeat (4) drive(1'b1, 1'b1, 1'b1, 4'hF, 32'h44332211);
    // random traffic
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 99) >= 2), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) != 0), 4'($urandom), $urandom);
    end
    drive(1'b1, 1'b0, 1'b0, 4'h0, 32'h0);
    @(posedge clk);
    #3;
    check("leftover", 32'(exp_q4.size() + exp_q3.size() + pop_q4.size() + pop_q3.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
